// File: rtl/ft600_bus_arbiter.sv
// ft600_bus_arbiter: sequences the FT600 245 sync-FIFO bus between RX and TX bursts.
// Owns OE_N/RD_N/WR_N and pad direction; fair RX/TX alternation, burst cap, one turnaround cycle.
module ft600_bus_arbiter #(
  parameter int DATA_W    = 16,
  parameter int BE_W      = 2,
  parameter int MAX_BURST = 256
) (
  input  logic              ftdi_clk,
  input  logic              rst,
  input  logic              ftdi_rxf_n,
  input  logic              ftdi_txe_n,
  output logic              ftdi_oe_n,
  output logic              ftdi_rd_n,
  output logic              ftdi_wr_n,
  input  logic [DATA_W-1:0] ftdi_data_i,
  input  logic [BE_W-1:0]   ftdi_be_i,
  output logic [DATA_W-1:0] ftdi_data_o,
  output logic [BE_W-1:0]   ftdi_be_o,
  output logic              ftdi_bus_oe,
  output logic [DATA_W-1:0] rx_data,
  output logic [BE_W-1:0]   rx_be,
  output logic              rx_wr,
  input  logic              rx_afull,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [BE_W-1:0]   tx_be,
  input  logic              tx_empty,
  output logic              tx_rd,
  output logic              busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic [2:0] {S_IDLE, S_RD_OE, S_RD, S_WR, S_TURN} state_e;
  typedef enum logic {DIR_RX, DIR_TX} dir_e;

  state_e             state_q, state_d;
  dir_e               last_q, last_d;
  logic               oe_n_q, oe_n_d;
  logic               rd_n_q, rd_n_d;
  logic               bus_oe_q, bus_oe_d;
  logic               rx_wr_q, rx_wr_d;
  logic [DATA_W-1:0]  rx_data_q, rx_data_d;
  logic [BE_W-1:0]    rx_be_q, rx_be_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic wr_n_c, tx_pop, rx_acc, rx_req, tx_req;

  assign wr_n_c = !(state_q == S_WR && !tx_empty);
  assign tx_pop = (state_q == S_WR) && !wr_n_c && !ftdi_txe_n;
  assign rx_acc = !ftdi_rxf_n && !rd_n_q;
  assign rx_req = !ftdi_rxf_n && !rx_afull;
  assign tx_req = !ftdi_txe_n && !tx_empty;

  always_ff @(posedge ftdi_clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      last_q    <= DIR_TX;
      oe_n_q    <= 1'b1;
      rd_n_q    <= 1'b1;
      bus_oe_q  <= 1'b0;
      rx_wr_q   <= 1'b0;
      rx_data_q <= '0;
      rx_be_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      oe_n_q    <= oe_n_d;
      rd_n_q    <= rd_n_d;
      bus_oe_q  <= bus_oe_d;
      rx_wr_q   <= rx_wr_d;
      rx_data_q <= rx_data_d;
      rx_be_q   <= rx_be_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    oe_n_d    = oe_n_q;
    rd_n_d    = rd_n_q;
    bus_oe_d  = bus_oe_q;
    rx_wr_d   = 1'b0;
    rx_data_d = rx_data_q;
    rx_be_d   = rx_be_q;
    cnt_d     = cnt_q;

    // Capture also happens on the exit edge, so at most one word lands after rx_afull.
    if (rx_acc) begin
      rx_wr_d   = 1'b1;
      rx_data_d = ftdi_data_i;
      rx_be_d   = ftdi_be_i;
    end

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        // last_grant is latched at grant time; TURN always follows, so this matches recording it in TURN.
        if (rx_req && (!tx_req || last_q == DIR_TX)) begin
          state_d = S_RD_OE;
          oe_n_d  = 1'b0;
          last_d  = DIR_RX;
        end else if (tx_req) begin
          state_d  = S_WR;
          bus_oe_d = 1'b1;
          last_d   = DIR_TX;
        end
      end
      S_RD_OE: begin
        state_d = S_RD;
        rd_n_d  = 1'b0;
      end
      S_RD: begin
        if (rx_acc) cnt_d = cnt_q + CNT_W'(1);
        if (ftdi_rxf_n || rx_afull || (rx_acc && cnt_q == CNT_LAST)) begin
          state_d = S_TURN;
          oe_n_d  = 1'b1;
          rd_n_d  = 1'b1;
        end
      end
      S_WR: begin
        if (tx_pop) cnt_d = cnt_q + CNT_W'(1);
        if (ftdi_txe_n || tx_empty || (tx_pop && cnt_q == CNT_LAST)) begin
          state_d  = S_TURN;
          bus_oe_d = 1'b0;
        end
      end
      S_TURN: begin
        state_d  = S_IDLE;
        oe_n_d   = 1'b1;
        rd_n_d   = 1'b1;
        bus_oe_d = 1'b0;
      end
      default: begin
        state_d  = S_IDLE;
        oe_n_d   = 1'b1;
        rd_n_d   = 1'b1;
        bus_oe_d = 1'b0;
      end
    endcase
  end

  assign ftdi_oe_n   = oe_n_q;
  assign ftdi_rd_n   = rd_n_q;
  assign ftdi_wr_n   = wr_n_c;
  assign ftdi_bus_oe = bus_oe_q;
  assign ftdi_data_o = tx_data;
  assign ftdi_be_o   = tx_be;
  assign rx_data     = rx_data_q;
  assign rx_be       = rx_be_q;
  assign rx_wr       = rx_wr_q;
  assign tx_rd       = tx_pop;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_ft600_bus_arbiter.sv
// Bench for ft600_bus_arbiter: arbitration table, directed burst sequences, and random traffic
// checked by FT600/FIFO queue models and a word-order scoreboard.
module tb_ft600_bus_arbiter;
  localparam int DW = 16;
  localparam int BW = 2;
  localparam int MB = 4;

  typedef logic [DW+BW-1:0] word_t;
  typedef struct { bit rx; int len; } burst_t;
  typedef struct packed {
    logic rxf_n; logic afull; logic txe_n; logic tx_empty;
    logic [5:0] exp1; logic [5:0] exp2;
  } vec_t;

  logic          ftdi_clk = 1'b0;
  logic          rst;
  logic          ftdi_rxf_n, ftdi_txe_n, ftdi_oe_n, ftdi_rd_n, ftdi_wr_n, ftdi_bus_oe;
  logic [DW-1:0] ftdi_data_i, ftdi_data_o, rx_data, tx_data;
  logic [BW-1:0] ftdi_be_i, ftdi_be_o, rx_be, tx_be;
  logic          rx_wr, rx_afull, tx_empty, tx_rd, busy;

  always #5 ftdi_clk = ~ftdi_clk;

  ft600_bus_arbiter #(.DATA_W(DW), .BE_W(BW), .MAX_BURST(MB)) dut (
    .ftdi_clk(ftdi_clk), .rst(rst), .ftdi_rxf_n(ftdi_rxf_n), .ftdi_txe_n(ftdi_txe_n),
    .ftdi_oe_n(ftdi_oe_n), .ftdi_rd_n(ftdi_rd_n), .ftdi_wr_n(ftdi_wr_n),
    .ftdi_data_i(ftdi_data_i), .ftdi_be_i(ftdi_be_i), .ftdi_data_o(ftdi_data_o),
    .ftdi_be_o(ftdi_be_o), .ftdi_bus_oe(ftdi_bus_oe), .rx_data(rx_data), .rx_be(rx_be),
    .rx_wr(rx_wr), .rx_afull(rx_afull), .tx_data(tx_data), .tx_be(tx_be),
    .tx_empty(tx_empty), .tx_rd(tx_rd), .busy(busy)
  );

  word_t  rx_src[$], rx_exp[$], tx_q[$], tx_ref[$];
  burst_t bursts[$];
  vec_t   vecs[8];
  int     n_cmp = 0, n_bad = 0;
  int     cyc, first_oe, first_rd, n_rxwr, n_txrd, n_wrlow, n_acc, burst_len, rx_total;
  bit     in_burst, burst_rx, ev_rd, ev_pop, rx_stall, txe_hold;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [5:0] outs();
    return {ftdi_oe_n, ftdi_rd_n, ftdi_wr_n, ftdi_bus_oe, busy, tx_rd};
  endfunction

  function automatic int bcode(int i);
    if (i >= bursts.size()) return -1;
    return (bursts[i].rx ? 1000 : 2000) + bursts[i].len;
  endfunction

  task automatic drive_pads();
    ftdi_rxf_n = rx_stall || (rx_src.size() == 0);
    {ftdi_data_i, ftdi_be_i} = (rx_src.size() > 0) ? rx_src[0] : '0;
    ftdi_txe_n = txe_hold;
    tx_empty = (tx_q.size() == 0);
    {tx_data, tx_be} = (tx_q.size() > 0) ? tx_q[0] : '0;
  endtask

  // Observe what the coming rising edge will do, using values settled since the last edge.
  task automatic sample();
    logic rd_acc, wr_acc;
    rd_acc = !ftdi_rd_n && !ftdi_rxf_n;
    wr_acc = !ftdi_wr_n && !ftdi_txe_n;
    chk("bus_oe_with_oe_n", 32'(ftdi_bus_oe && !ftdi_oe_n), 32'd0);
    chk("wr_n_without_bus_oe", 32'(!ftdi_wr_n && !ftdi_bus_oe), 32'd0);
    chk("tx_rd_vs_write_accept", 32'(tx_rd), 32'(wr_acc));
    if (rx_wr) begin
      n_rxwr++;
      if (rx_exp.size() == 0) chk("rx_wr_without_read", 32'(rx_wr), 32'd0);
      else chk("rx_word", 32'({rx_data, rx_be}), 32'(rx_exp.pop_front()));
    end
    if (rd_acc) begin
      chk("read_without_oe", 32'(ftdi_oe_n), 32'd0);
      rx_exp.push_back(rx_src[0]);
      n_acc++;
      burst_len++;
      chk("rx_burst_cap", 32'(burst_len <= MB), 32'd1);
    end
    if (wr_acc) begin
      if (tx_ref.size() == 0) chk("write_with_nothing_queued", 32'(wr_acc), 32'd0);
      else chk("tx_word", 32'({ftdi_data_o, ftdi_be_o}), 32'(tx_ref.pop_front()));
      burst_len++;
      chk("tx_burst_cap", 32'(burst_len <= MB), 32'd1);
    end
    if (!ftdi_wr_n) n_wrlow++;
    if (tx_rd) n_txrd++;
    if (!ftdi_oe_n && first_oe < 0) first_oe = cyc;
    if (!ftdi_rd_n && first_rd < 0) first_rd = cyc;
    if (busy) begin
      in_burst = 1'b1;
      if (!ftdi_oe_n) burst_rx = 1'b1;
    end else if (in_burst) begin
      bursts.push_back('{burst_rx, burst_len});
      in_burst = 1'b0; burst_rx = 1'b0; burst_len = 0;
    end
    ev_rd  = rd_acc;
    ev_pop = tx_rd;
    cyc++;
  endtask

  task automatic step();
    @(negedge ftdi_clk);
    sample();
    @(posedge ftdi_clk);
    #1;
    if (ev_rd && rx_src.size() > 0) rx_src.delete(0);
    if (ev_pop && tx_q.size() > 0) tx_q.delete(0);
    drive_pads();
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic wait_idle(int budget, string name);
    int  k = 0;
    bit  done = 1'b0;
    while (!done && k < budget) begin
      step();
      k++;
      done = !busy && !in_burst && rx_src.size() == 0 && tx_q.size() == 0 && rx_exp.size() == 0;
    end
    chk(name, 32'(done), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_src.delete(); rx_exp.delete(); tx_q.delete(); tx_ref.delete(); bursts.delete();
    cyc = 0; first_oe = -1; first_rd = -1; n_rxwr = 0; n_txrd = 0; n_wrlow = 0; n_acc = 0;
    burst_len = 0; in_burst = 0; burst_rx = 0; rx_stall = 0; txe_hold = 1; rx_afull = 0;
    drive_pads();
    @(posedge ftdi_clk); #1;
    rst = 1'b0;
  endtask

  task automatic push_rx(word_t w);
    rx_src.push_back(w);
  endtask

  task automatic push_tx(word_t w);
    tx_q.push_back(w);
    tx_ref.push_back(w);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] t1_words[8];
    int held, k;

    //             rxf afull txe empty  {oe_n,rd_n,wr_n,bus_oe,busy,tx_rd} after edge 1 / edge 2
    vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b1, 6'b111000, 6'b111000};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 6'b011010, 6'b001010};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 6'b111000, 6'b111000};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'b110111, 6'b110111};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b011010, 6'b001010};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 6'b111000, 6'b111000};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 6'b110111, 6'b110111};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 6'b111000, 6'b111000};
    t1_words = '{16'h3130, 16'h3332, 16'h3534, 16'h3736, 16'h3938, 16'h6261, 16'h6463, 16'h6665};

    rst = 1'b1;
    ftdi_rxf_n = 1'b1; ftdi_txe_n = 1'b1; rx_afull = 1'b0; tx_empty = 1'b1;
    ftdi_data_i = '0; ftdi_be_i = '0; tx_data = 16'hDEAD; tx_be = '1;
    #1;
    chk("reset_state", 32'({outs(), rx_wr, rx_data, rx_be}), 32'({6'b111000, 1'b0, 16'h0, 2'b00}));

    for (int i = 0; i < 8; i++) begin
      rst = 1'b1;
      ftdi_rxf_n = vecs[i].rxf_n; rx_afull = vecs[i].afull;
      ftdi_txe_n = vecs[i].txe_n; tx_empty = vecs[i].tx_empty;
      @(posedge ftdi_clk); #1;
      rst = 1'b0;
      @(posedge ftdi_clk); #1;
      chk($sformatf("arb_vec%0d_edge1", i), 32'(outs()), 32'(vecs[i].exp1));
      @(posedge ftdi_clk); #1;
      chk($sformatf("arb_vec%0d_edge2", i), 32'(outs()), 32'(vecs[i].exp2));
    end

    // RX only, 8 words: oe_n leads rd_n by one cycle, two capped bursts of MB words
    do_reset();
    for (int i = 0; i < 8; i++) push_rx({t1_words[i], 2'b11});
    drive_pads();
    wait_idle(200, "t1_complete");
    chk("t1_oe_to_rd_lead", 32'(first_rd - first_oe), 32'd1);
    chk("t1_rx_wr_count", 32'(n_rxwr), 32'd8);
    chk("t1_no_writes", 32'(n_wrlow), 32'd0);
    chk("t1_burst0", 32'(bcode(0)), 32'd1004);
    chk("t1_burst1", 32'(bcode(1)), 32'd1004);
    chk("t1_busy_end", 32'(busy), 32'd0);

    // TX only, 4 words
    do_reset();
    for (int i = 0; i < 4; i++) push_tx({16'hA0A1 + 16'(i) * 16'h0101, 2'(i)});
    txe_hold = 1'b0;
    drive_pads();
    wait_idle(100, "t2_complete");
    chk("t2_wr_n_low_cycles", 32'(n_wrlow), 32'd4);
    chk("t2_tx_rd_count", 32'(n_txrd), 32'd4);
    chk("t2_burst0", 32'(bcode(0)), 32'd2004);
    chk("t2_burst_count", 32'(bursts.size()), 32'd1);

    // contention from reset: RX first, then TX
    do_reset();
    for (int i = 0; i < 3; i++) push_rx({16'h1000 + 16'(i), 2'b01});
    for (int i = 0; i < 2; i++) push_tx({16'h2000 + 16'(i), 2'b10});
    txe_hold = 1'b0;
    drive_pads();
    wait_idle(100, "t3_complete");
    chk("t3_burst0", 32'(bcode(0)), 32'd1003);
    chk("t3_burst1", 32'(bcode(1)), 32'd2002);

    // burst cap with 10 RX words and pending TX: 4, TX, 4, 2
    do_reset();
    for (int i = 0; i < 10; i++) push_rx({16'h4000 + 16'(i), 2'b11});
    for (int i = 0; i < 2; i++) push_tx({16'h5000 + 16'(i), 2'b11});
    txe_hold = 1'b0;
    drive_pads();
    wait_idle(300, "t4_complete");
    chk("t4_burst0", 32'(bcode(0)), 32'd1004);
    chk("t4_burst1", 32'(bcode(1)), 32'd2002);
    chk("t4_burst2", 32'(bcode(2)), 32'd1004);
    chk("t4_burst3", 32'(bcode(3)), 32'd1002);
    chk("t4_rx_wr_count", 32'(n_rxwr), 32'd10);

    // rx_afull mid-burst
    do_reset();
    for (int i = 0; i < 6; i++) push_rx({16'h6000 + 16'(i), 2'b11});
    drive_pads();
    k = 0;
    while (n_acc < 2 && k < 50) begin step(); k++; end
    chk("t5_reached_two_reads", 32'(n_acc), 32'd2);
    rx_afull = 1'b1;
    step();
    chk("t5_rd_n_released", 32'(ftdi_rd_n), 32'd1);
    chk("t5_at_most_one_extra", 32'(n_acc <= 3), 32'd1);
    held = n_acc;
    run(3);
    chk("t5_no_read_while_afull", 32'(n_acc), 32'(held));
    rx_afull = 1'b0;
    wait_idle(100, "t5_complete");
    chk("t5_rx_wr_count", 32'(n_rxwr), 32'd6);

    // reset pulsed mid-WR
    do_reset();
    for (int i = 0; i < 4; i++) push_tx({16'h7000 + 16'(i), 2'b11});
    txe_hold = 1'b0;
    drive_pads();
    k = 0;
    while (n_wrlow < 1 && k < 20) begin step(); k++; end
    chk("t6_write_started", 32'(n_wrlow >= 1), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_async_reset_outputs", 32'(outs()), 32'b111000);
    @(posedge ftdi_clk); #1;
    txe_hold = 1'b1;
    drive_pads();
    rst = 1'b0;
    run(2);
    chk("t6_idle_after_release", 32'(busy), 32'd0);
    txe_hold = 1'b0;
    drive_pads();
    wait_idle(100, "t6_complete");
    chk("t6_tx_rd_total", 32'(n_txrd), 32'd4);

    // randomized traffic against the queue models
    do_reset();
    rx_total = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3) == 0 && rx_src.size() < 20) begin
        push_rx(word_t'($urandom));
        rx_total++;
      end
      if ($urandom_range(4) == 0 && tx_q.size() < 20) push_tx(word_t'($urandom));
      rx_stall = ($urandom_range(5) == 0);
      txe_hold = ($urandom_range(3) == 0);
      rx_afull = ($urandom_range(9) == 0);
      drive_pads();
      step();
    end
    rx_stall = 1'b0; txe_hold = 1'b0; rx_afull = 1'b0;
    drive_pads();
    wait_idle(2000, "rand_drain");
    chk("rand_rx_words_delivered", 32'(n_rxwr), 32'(rx_total));
    chk("rand_tx_words_left", 32'(tx_ref.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
